// File: rtl/neuro_pkg.sv
// neuro_pkg: FSM state codes and bipolar/saturating arithmetic helpers for the Hopfield core
package neuro_pkg;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_CLEAR    = 3'd1;
  localparam state_t S_LEARN_RD = 3'd2;
  localparam state_t S_LEARN_WR = 3'd3;
  localparam state_t S_MAC      = 3'd4;
  localparam state_t S_UPD      = 3'd5;
  localparam state_t S_FIN      = 3'd6;
  function automatic int bipolar(input logic b);
    return b ? 1 : -1;
  endfunction
  function automatic int sat_add(input int a, input int b, input int w);
    int s, hi, lo;
    s = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/hopfield_wram.sv
// hopfield_wram: single-port synchronous weight RAM, 1-cycle read, write-first
module hopfield_wram #(
  parameter int DEPTH = 625,
  parameter int WW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wdata,
  output logic [WW-1:0] rdata
);
  logic [WW-1:0] mem_q [DEPTH];
  logic [WW-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we) mem_q[addr] <= wdata;
  // only the output register resets; the array keeps its contents
  always_ff @(posedge clk)
    if (!rst) rdata_q <= '0;
    else if (we | re) rdata_q <= we ? wdata : mem_q[addr];
  assign rdata = rdata_q;
endmodule

// File: rtl/hopfield_recall_engine.sv
// hopfield_recall_engine: Hopfield associative memory with Hebbian learning,
// weight clear and one-MAC-per-cycle asynchronous recall
module hopfield_recall_engine
  import neuro_pkg::*;
#(
  parameter int N = 25,
  parameter int WW = 8,
  parameter int MAX_ITER = 16,
  localparam int AW = $clog2(N*N),
  localparam int ACC_W = WW + $clog2(N) + 1,
  localparam int IW = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_clear,
  input  logic          cmd_learn,
  input  logic          cmd_recall,
  input  logic          pat_we,
  input  logic [N-1:0]  pat_in,
  input  logic          w_we,
  input  logic          w_re,
  input  logic [AW-1:0] w_addr,
  input  logic [WW-1:0] w_wdata,
  output logic [WW-1:0] w_rdata,
  output logic          busy,
  output logic          done,
  output logic          converged,
  output logic [IW-1:0] iter,
  output logic [N-1:0]  state_out
);
  localparam int XW = $clog2(N + 2);
  localparam logic [XW-1:0] NL = XW'(N);
  localparam logic [XW-1:0] NM1 = XW'(N - 1);
  localparam logic [XW-1:0] NM2 = XW'(N - 2);
  localparam logic [AW-1:0] A_LAST = AW'(N*N - 1);
  localparam logic [IW-1:0] I_MAX = IW'(MAX_ITER);
  state_t state_q, state_d;
  logic [XW-1:0] i_q, i_d, j_q, j_d, jn;
  logic signed [ACC_W-1:0] acc_q, acc_d, ext, term;
  logic vld_q, vld_d, sub_q, sub_d, chg_q, chg_d, conv_q, conv_d, done_q, done_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [N-1:0] s_q, s_d;
  logic ram_we, ram_re;
  logic [AW-1:0] ram_addr, ij;
  logic [WW-1:0] ram_wdata, ram_rdata;
  logic pos, neg, si, flip;
  assign ij = AW'(32'(i_q) * N + 32'(j_q));
  assign ext = ACC_W'($signed(ram_rdata));
  assign term = sub_q ? -ext : ext;
  assign pos = ~acc_q[ACC_W-1] & (|acc_q);
  assign neg = acc_q[ACC_W-1];
  assign si = s_q[i_q];
  assign flip = (pos & ~si) | (neg & si);
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    jn = '0;
    acc_d = acc_q;
    vld_d = 1'b0;
    sub_d = sub_q;
    chg_d = chg_q;
    conv_d = conv_q;
    done_d = 1'b0;
    iter_d = iter_q;
    s_d = s_q;
    ram_we = 1'b0;
    ram_re = 1'b0;
    ram_addr = ij;
    ram_wdata = '0;
    case (state_q)
      S_IDLE:
        if (cmd_clear | cmd_learn | cmd_recall) begin
          conv_d = 1'b0;
          iter_d = '0;
          chg_d = 1'b0;
          acc_d = '0;
          i_d = '0;
          j_d = '0;
          state_d = cmd_clear ? S_CLEAR : cmd_learn ? S_LEARN_WR : S_MAC;
          // learn prefetches w(0,1) so its first write lands on the next cycle
          if (!cmd_clear && cmd_learn) begin
            j_d = XW'(1);
            ram_re = 1'b1;
            ram_addr = AW'(1);
          end
        end else if (pat_we) begin
          s_d = pat_in;
        end else if (w_we | w_re) begin
          ram_we = w_we;
          ram_re = ~w_we;
          ram_addr = w_addr;
          ram_wdata = w_wdata;
        end
      S_CLEAR: begin
        ram_we = 1'b1;
        j_d = (j_q == NM1) ? '0 : j_q + 1'b1;
        i_d = (j_q == NM1) ? i_q + 1'b1 : i_q;
        state_d = (ij == A_LAST) ? S_FIN : S_CLEAR;
      end
      S_LEARN_RD: begin
        ram_re = 1'b1;
        state_d = S_LEARN_WR;
      end
      S_LEARN_WR: begin
        ram_we = 1'b1;
        ram_wdata = WW'(sat_add(int'($signed(ram_rdata)), bipolar(s_q[i_q]) * bipolar(s_q[j_q]), WW));
        jn = (j_q + 1'b1 == i_q) ? j_q + 2'd2 : j_q + 1'b1;
        j_d = (jn >= NL) ? '0 : jn;
        i_d = (jn >= NL) ? i_q + 1'b1 : i_q;
        state_d = (i_q == NM1 && j_q == NM2) ? S_FIN : S_LEARN_RD;
      end
      S_MAC: begin
        if (vld_q) acc_d = acc_q + term;
        if (j_q == NL) begin
          state_d = S_UPD;
        end else begin
          ram_re = (j_q != i_q);
          vld_d = ram_re;
          sub_d = ~s_q[j_q];
          j_d = j_q + 1'b1;
        end
      end
      S_UPD: begin
        acc_d = '0;
        j_d = '0;
        s_d[i_q] = si ^ flip;
        state_d = S_MAC;
        if (i_q == NM1) begin
          i_d = '0;
          chg_d = 1'b0;
          iter_d = iter_q + 1'b1;
          conv_d = ~(chg_q | flip);
          state_d = (~(chg_q | flip) || iter_d == I_MAX) ? S_FIN : S_MAC;
        end else begin
          i_d = i_q + 1'b1;
          chg_d = chg_q | flip;
        end
      end
      S_FIN: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= S_IDLE;
      i_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      vld_q <= 1'b0;
      sub_q <= 1'b0;
      chg_q <= 1'b0;
      conv_q <= 1'b0;
      done_q <= 1'b0;
      iter_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      acc_q <= acc_d;
      vld_q <= vld_d;
      sub_q <= sub_d;
      chg_q <= chg_d;
      conv_q <= conv_d;
      done_q <= done_d;
      iter_q <= iter_d;
      s_q <= s_d;
    end
  hopfield_wram #(.DEPTH(N*N), .WW(WW), .AW(AW)) u_wram (
    .clk(clk),
    .rst(rst),
    .we(ram_we & rst),
    .re(ram_re),
    .addr(ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign converged = conv_q;
  assign iter = iter_q;
  assign state_out = s_q;
  assign w_rdata = ram_rdata;
endmodule

// File: tb/tb_hopfield_recall_engine.sv
// tb_hopfield_recall_engine: randomized self-checking bench against a behavioural Hopfield model
module tb_hopfield_recall_engine;
  localparam int N = 25, WW = 8, MAX_ITER = 16;
  localparam int AW = $clog2(N*N), IW = $clog2(MAX_ITER + 1);
  localparam logic [N-1:0] P = 25'b0111010010100101001001111;
  localparam int HI = 2**(WW-1) - 1, LO = -(2**(WW-1));
  logic clk = 0, rst = 0;
  logic cmd_clear = 0, cmd_learn = 0, cmd_recall = 0, pat_we = 0, w_we = 0, w_re = 0;
  logic [N-1:0] pat_in = '0;
  logic [AW-1:0] w_addr = '0;
  logic [WW-1:0] w_wdata = '0;
  logic [WW-1:0] w_rdata;
  logic busy, done, converged;
  logic [IW-1:0] iter;
  logic [N-1:0] state_out;
  int checks = 0, fails = 0;
  int mw [N*N];
  logic [N-1:0] ms = '0;

  always #5 clk = ~clk;

  hopfield_recall_engine #(.N(N), .WW(WW), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .cmd_clear(cmd_clear), .cmd_learn(cmd_learn), .cmd_recall(cmd_recall),
    .pat_we(pat_we), .pat_in(pat_in), .w_we(w_we), .w_re(w_re), .w_addr(w_addr), .w_wdata(w_wdata),
    .w_rdata(w_rdata), .busy(busy), .done(done), .converged(converged), .iter(iter), .state_out(state_out)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int bip(input logic b);
    return b ? 1 : -1;
  endfunction

  task automatic m_clear;
    foreach (mw[k]) mw[k] = 0;
  endtask

  task automatic m_learn;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j) begin
          int v;
          v = mw[i*N+j] + bip(ms[i]) * bip(ms[j]);
          mw[i*N+j] = v > HI ? HI : v < LO ? LO : v;
        end
  endtask

  task automatic m_recall(output int sweeps, output bit conv);
    sweeps = 0;
    conv = 0;
    while (sweeps < MAX_ITER) begin
      bit ch;
      ch = 0;
      for (int i = 0; i < N; i++) begin
        int sum;
        sum = 0;
        for (int j = 0; j < N; j++) if (j != i) sum += mw[i*N+j] * bip(ms[j]);
        if (sum > 0 && !ms[i]) begin ms[i] = 1; ch = 1; end
        else if (sum < 0 && ms[i]) begin ms[i] = 0; ch = 1; end
      end
      sweeps++;
      if (!ch) begin conv = 1; break; end
    end
  endtask

  // kind: 0 clear, 1 learn, 2 recall; noise pulses every command input mid-run
  task automatic run_cmd(input int kind, input int exp_cyc, input string nm, input bit noise);
    int cnt;
    cnt = 0;
    cmd_clear = (kind == 0);
    cmd_learn = (kind == 1);
    cmd_recall = (kind == 2);
    tick;
    cmd_clear = 0; cmd_learn = 0; cmd_recall = 0;
    checks++;
    if (busy !== 1'b1) begin fails++; $display("FAIL %s_busy: got %b want 1", nm, busy); end
    do begin
      if (noise && cnt == 50) begin
        cmd_clear = 1; cmd_learn = 1; cmd_recall = 1; pat_we = 1; pat_in = '1;
        w_we = 1; w_re = 1; w_addr = AW'(1); w_wdata = 8'd77;
      end
      if (noise && cnt == 51) begin
        cmd_clear = 0; cmd_learn = 0; cmd_recall = 0; pat_we = 0; w_we = 0; w_re = 0;
      end
      tick;
      cnt++;
    end while (done !== 1'b1 && cnt < 20000);
    checks++;
    if (cnt != exp_cyc) begin fails++; $display("FAIL %s_cycles: got %0d want %0d", nm, cnt, exp_cyc); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL %s_busy_at_done: got %b want 0", nm, busy); end
    tick;
    checks++;
    if (done !== 1'b0) begin fails++; $display("FAIL %s_done_pulse: got %b want 0", nm, done); end
  endtask

  task automatic host_write(input int a, input int d);
    w_we = 1; w_addr = AW'(a); w_wdata = WW'(d);
    tick;
    w_we = 0;
    mw[a] = d;
  endtask

  task automatic host_read(input int a, output int v);
    w_re = 1; w_addr = AW'(a);
    tick;
    w_re = 0;
    v = int'($signed(w_rdata));
  endtask

  task automatic load(input logic [N-1:0] p);
    pat_we = 1; pat_in = p;
    tick;
    pat_we = 0;
    ms = p;
  endtask

  task automatic test_reset;
    rst = 0;
    tick;
    tick;
    checks += 6;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    if (converged !== 1'b0) begin fails++; $display("FAIL reset_conv: got %b want 0", converged); end
    if (iter !== '0) begin fails++; $display("FAIL reset_iter: got %0d want 0", iter); end
    if (state_out !== '0) begin fails++; $display("FAIL reset_state: got %h want 0", state_out); end
    if (w_rdata !== '0) begin fails++; $display("FAIL reset_rdata: got %h want 0", w_rdata); end
    rst = 1;
    tick;
  endtask

  task automatic test_clear_learn;
    int v;
    m_clear();
    run_cmd(0, N*N + 1, "clear", 0);
    load(P);
    checks++;
    if (state_out !== P) begin fails++; $display("FAIL load_state: got %h want %h", state_out, P); end
    m_learn();
    run_cmd(1, 2*N*(N-1), "learn", 0);
    host_read(1, v);
    checks++;
    if (v != mw[1]) begin fails++; $display("FAIL learn_w01: got %0d want %0d", v, mw[1]); end
    host_read(0, v);
    checks++;
    if (v != mw[0]) begin fails++; $display("FAIL learn_w00: got %0d want %0d", v, mw[0]); end
    for (int k = 0; k < 6; k++) begin
      int a;
      a = $urandom_range(N*N - 1);
      host_read(a, v);
      checks++;
      if (v != mw[a]) begin fails++; $display("FAIL learn_w[%0d]: got %0d want %0d", a, v, mw[a]); end
    end
  endtask

  task automatic test_saturation;
    int v, jd;
    jd = 1;
    while (P[jd] == P[0]) jd++;
    host_write(1, HI);
    host_write(jd, LO);
    host_write(N, HI - 1);
    load(P);
    m_learn();
    run_cmd(1, 2*N*(N-1), "learn_sat", 0);
    host_read(1, v);
    checks++;
    if (v != mw[1]) begin fails++; $display("FAIL sat_hi: got %0d want %0d", v, mw[1]); end
    host_read(jd, v);
    checks++;
    if (v != mw[jd]) begin fails++; $display("FAIL sat_lo: got %0d want %0d", v, mw[jd]); end
    host_read(N, v);
    checks++;
    if (v != mw[N]) begin fails++; $display("FAIL sat_near: got %0d want %0d", v, mw[N]); end
  endtask

  task automatic test_reset_mid;
    int v;
    load(N'($urandom));
    cmd_recall = 1;
    tick;
    cmd_recall = 0;
    repeat (40) tick;
    rst = 0;
    tick;
    checks += 5;
    if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin fails++; $display("FAIL midrst_done: got %b want 0", done); end
    if (state_out !== '0) begin fails++; $display("FAIL midrst_state: got %h want 0", state_out); end
    if (iter !== '0) begin fails++; $display("FAIL midrst_iter: got %0d want 0", iter); end
    if (w_rdata !== '0) begin fails++; $display("FAIL midrst_rdata: got %h want 0", w_rdata); end
    rst = 1;
    ms = '0;
    tick;
    for (int k = 0; k < 4; k++) begin
      int a;
      a = (k == 0) ? 1 : $urandom_range(N*N - 1);
      host_read(a, v);
      checks++;
      if (v != mw[a]) begin fails++; $display("FAIL midrst_w[%0d]: got %0d want %0d", a, v, mw[a]); end
    end
  endtask

  task automatic check_recall(input string nm, input bit noise);
    int sw;
    bit cv;
    m_recall(sw, cv);
    run_cmd(2, sw*N*(N+2) + 1, nm, noise);
    checks += 3;
    if (state_out !== ms) begin fails++; $display("FAIL %s_state: got %h want %h", nm, state_out, ms); end
    if (converged !== cv) begin fails++; $display("FAIL %s_conv: got %b want %b", nm, converged, cv); end
    if (iter !== IW'(sw)) begin fails++; $display("FAIL %s_iter: got %0d want %0d", nm, iter, sw); end
  endtask

  task automatic test_recall;
    m_clear();
    run_cmd(0, N*N + 1, "clear_r", 0);
    load(P);
    m_learn();
    run_cmd(1, 2*N*(N-1), "learn_r", 0);
    load(P ^ ((N'(1) << 0) | (N'(1) << 7) | (N'(1) << 19)));
    check_recall("recall", 0);
  endtask

  task automatic test_stable;
    load(P);
    check_recall("stable", 0);
  endtask

  task automatic test_random;
    for (int t = 0; t < 3; t++) begin
      m_clear();
      run_cmd(0, N*N + 1, "clear_rnd", 0);
      for (int k = 0; k < 2; k++) begin
        load(N'($urandom));
        m_learn();
        run_cmd(1, 2*N*(N-1), "learn_rnd", 0);
      end
      for (int k = 0; k < 3; k++) host_write($urandom_range(N*N - 1), $urandom_range(HI) - $urandom_range(HI));
      load(N'($urandom));
      check_recall("random", 0);
    end
  endtask

  task automatic test_oscillation;
    int v;
    m_clear();
    run_cmd(0, N*N + 1, "clear_osc", 0);
    host_write(1, 1);
    host_write(N, -1);
    load(N'(2'b01));
    check_recall("osc", 1);
    host_read(1, v);
    checks++;
    if (v != 1) begin fails++; $display("FAIL osc_w01_kept: got %0d want 1", v); end
  endtask

  initial begin
    test_reset();
    test_clear_learn();
    test_saturation();
    test_reset_mid();
    test_recall();
    test_stable();
    test_random();
    test_oscillation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
